// File: rtl/unpacker_pipe.sv
`default_nettype none
// ============================================================================
// Module      : unpacker_pipe
// Description : Two-stage pipelined operand unpacker for the FPU front end.
//               Splits packed operands A and B (wide or narrow format) into
//               sign, unbiased exponent, leading-zero count, significand and
//               class flags, and produces the propagated quiet-NaN
//               significand. A valid/ready handshake lets the issue logic
//               apply backpressure.
//
// Ports       : clk, rst            clock, synchronous active-high reset
//               in_valid/in_ready   input handshake
//               fa2, fb2            packed operands (narrow = left-justified)
//               db                  1 = wide format, 0 = narrow format
//               normal              1 = left-normalise significand by lz
//               out_valid/out_ready output handshake
//               sa, sb              signs
//               ea, eb              unbiased two's-complement exponents
//               lza, lzb            significand leading-zero counts
//               fa, fb              significands, hidden bit at MSB
//               fla, flb            class flags {SNAN, NAN, INF, ZERO}
//               nan                 propagated quiet-NaN significand
//
// Revision    : 1.0 - initial pipelined release
// ============================================================================
module unpacker_pipe #(
    parameter int EXP_W  = 11,
    parameter int MAN_W  = 52,
    parameter int SEXP_W = 8,
    parameter int SMAN_W = 23,
    parameter int LZ_W   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   fa2,
    input  logic [EXP_W+MAN_W:0]   fb2,
    input  logic                   db,
    input  logic                   normal,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sa,
    output logic                   sb,
    output logic [EXP_W-1:0]       ea,
    output logic [EXP_W-1:0]       eb,
    output logic [LZ_W-1:0]        lza,
    output logic [LZ_W-1:0]        lzb,
    output logic [MAN_W:0]         fa,
    output logic [MAN_W:0]         fb,
    output logic [3:0]             fla,
    output logic [3:0]             flb,
    output logic [MAN_W:0]         nan
);

    localparam int W     = EXP_W + MAN_W + 1;
    localparam int SIG_W = MAN_W + 1;

    // Flag bit positions
    localparam int FL_ZERO = 0;
    localparam int FL_INF  = 1;
    localparam int FL_NAN  = 2;
    localparam int FL_SNAN = 3;

    localparam logic [EXP_W-1:0] BIAS_WIDE   = EXP_W'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W-1:0] BIAS_NARROW = EXP_W'((1 << (SEXP_W - 1)) - 1);
    localparam logic [EXP_W-1:0] EXP_ONE     = EXP_W'(1);
    // Hidden bit plus quiet bit; also the canonical quiet NaN
    localparam logic [SIG_W-1:0] QNAN_BITS   = {2'b11, {(MAN_W - 1){1'b0}}};

    // Leading-zero count, MSB first
    function automatic logic [LZ_W-1:0] lzc(input logic [SIG_W-1:0] v);
        logic [LZ_W-1:0] cnt;
        logic            found;
        cnt   = '0;
        found = 1'b0;
        for (int k = SIG_W - 1; k >= 0; k--) begin
            if (!found) begin
                if (v[k]) begin
                    found = 1'b1;
                end else begin
                    cnt = cnt + LZ_W'(1);
                end
            end
        end
        return cnt;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q;
    logic out_valid_q;
    logic w_s2_load;
    logic w_in_ready;

    assign w_s2_load  = !out_valid_q || out_ready;
    assign w_in_ready = !s1_valid_q || w_s2_load;

    // ------------------------------------------------------------------
    // Stage 1 next-state (decode) and registers
    // ------------------------------------------------------------------
    logic [W-1:0]     w_ops    [2];
    logic             s1_s_d   [2];
    logic [EXP_W-1:0] s1_e_d   [2];
    logic [LZ_W-1:0]  s1_lz_d  [2];
    logic [SIG_W-1:0] s1_sig_d [2];
    logic [3:0]       s1_fl_d  [2];

    logic             s1_normal_q;
    logic             s1_s_q   [2];
    logic [EXP_W-1:0] s1_e_q   [2];
    logic [LZ_W-1:0]  s1_lz_q  [2];
    logic [SIG_W-1:0] s1_sig_q [2];
    logic [3:0]       s1_fl_q  [2];

    // Stage 2 next-state and output registers
    logic [EXP_W-1:0] out_e_d  [2];
    logic [SIG_W-1:0] out_f_d  [2];
    logic [SIG_W-1:0] w_nan_src;
    logic [SIG_W-1:0] nan_d;

    logic             out_s_q  [2];
    logic [EXP_W-1:0] out_e_q  [2];
    logic [LZ_W-1:0]  out_lz_q [2];
    logic [SIG_W-1:0] out_f_q  [2];
    logic [3:0]       out_fl_q [2];
    logic [SIG_W-1:0] nan_q;

    assign w_ops[0] = fa2;
    assign w_ops[1] = fb2;

    for (genvar i = 0; i < 2; i++) begin : g_op
        logic [EXP_W-1:0]  w_ew;
        logic [MAN_W-1:0]  w_fw;
        logic [SEXP_W-1:0] w_en;
        logic [SMAN_W-1:0] w_fn;
        logic [EXP_W-1:0]  w_e_field;
        logic              w_e_zero;
        logic              w_e_ones;
        logic              w_f_zero;
        logic              w_is_zero;
        logic              w_is_inf;
        logic              w_is_nan;
        logic [SIG_W-1:0]  w_shifted;

        // Both field splits are taken from the MSB end; db picks one
        assign w_ew = w_ops[i][W-2 -: EXP_W];
        assign w_fw = w_ops[i][MAN_W-1:0];
        assign w_en = w_ops[i][W-2 -: SEXP_W];
        assign w_fn = w_ops[i][W-2-SEXP_W -: SMAN_W];

        assign w_e_zero = db ? (w_ew == '0) : (w_en == '0);
        assign w_e_ones = db ? (&w_ew)      : (&w_en);
        assign w_f_zero = db ? (w_fw == '0) : (w_fn == '0);

        assign w_is_zero = w_e_zero && w_f_zero;
        assign w_is_inf  = w_e_ones && w_f_zero;
        assign w_is_nan  = w_e_ones && !w_f_zero;

        // Narrow fraction is left-aligned so both formats share one layout
        assign s1_sig_d[i] = db ? {~w_e_zero, w_fw}
                                : {~w_e_zero, w_fn, {(MAN_W - SMAN_W){1'b0}}};

        // Denormals use exponent 1; modular subtract gives the sign-extended result
        assign w_e_field = db ? w_ew : {{(EXP_W - SEXP_W){1'b0}}, w_en};
        assign s1_e_d[i] = (w_e_zero ? EXP_ONE : w_e_field)
                         - (db ? BIAS_WIDE : BIAS_NARROW);

        // Fraction MSB sits at significand bit MAN_W-1 in both formats
        assign s1_fl_d[i] = {w_is_nan && !s1_sig_d[i][MAN_W-1], w_is_nan, w_is_inf, w_is_zero};
        assign s1_lz_d[i] = (w_is_zero || w_is_inf || w_is_nan) ? '0 : lzc(s1_sig_d[i]);
        assign s1_s_d[i]  = w_ops[i][W-1];

        // Stage 2: optional normalise, specials clear exponent
        assign w_shifted  = s1_normal_q ? (s1_sig_q[i] << s1_lz_q[i]) : s1_sig_q[i];
        assign out_f_d[i] = (s1_fl_q[i][FL_ZERO] || s1_fl_q[i][FL_INF]) ? '0 : w_shifted;
        assign out_e_d[i] = (s1_fl_q[i][FL_ZERO] || s1_fl_q[i][FL_INF] || s1_fl_q[i][FL_NAN])
                          ? '0 : s1_e_q[i];
    end

    // NaN source priority: A, then B. The NaN lz is 0 so the raw significand is the payload.
    assign w_nan_src = s1_fl_q[0][FL_NAN] ? s1_sig_q[0] : s1_sig_q[1];
    assign nan_d     = (s1_fl_q[0][FL_NAN] || s1_fl_q[1][FL_NAN]) ? (w_nan_src | QNAN_BITS)
                                                                 : QNAN_BITS;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_normal_q <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                s1_s_q[k]   <= 1'b0;
                s1_e_q[k]   <= '0;
                s1_lz_q[k]  <= '0;
                s1_sig_q[k] <= '0;
                s1_fl_q[k]  <= '0;
            end
        end else if (w_in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_normal_q <= normal;
                for (int k = 0; k < 2; k++) begin
                    s1_s_q[k]   <= s1_s_d[k];
                    s1_e_q[k]   <= s1_e_d[k];
                    s1_lz_q[k]  <= s1_lz_d[k];
                    s1_sig_q[k] <= s1_sig_d[k];
                    s1_fl_q[k]  <= s1_fl_d[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            nan_q       <= '0;
            for (int k = 0; k < 2; k++) begin
                out_s_q[k]  <= 1'b0;
                out_e_q[k]  <= '0;
                out_lz_q[k] <= '0;
                out_f_q[k]  <= '0;
                out_fl_q[k] <= '0;
            end
        end else if (w_s2_load) begin
            out_valid_q <= s1_valid_q;
            // Data held when the stage drains empty; only valid gates use
            if (s1_valid_q) begin
                nan_q <= nan_d;
                for (int k = 0; k < 2; k++) begin
                    out_s_q[k]  <= s1_s_q[k];
                    out_e_q[k]  <= out_e_d[k];
                    out_lz_q[k] <= s1_lz_q[k];
                    out_f_q[k]  <= out_f_d[k];
                    out_fl_q[k] <= s1_fl_q[k];
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = out_valid_q;
    assign sa        = out_s_q[0];
    assign sb        = out_s_q[1];
    assign ea        = out_e_q[0];
    assign eb        = out_e_q[1];
    assign lza       = out_lz_q[0];
    assign lzb       = out_lz_q[1];
    assign fa        = out_f_q[0];
    assign fb        = out_f_q[1];
    assign fla       = out_fl_q[0];
    assign flb       = out_fl_q[1];
    assign nan       = nan_q;

endmodule
`default_nettype wire

// File: tb/tb_unpacker_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_unpacker_pipe
// Description : Scoreboard bench for unpacker_pipe. Stimulus pushes the
//               hand-computed expected result on acceptance; a monitor
//               compares the queue head whenever out_valid is high and pops
//               on out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unpacker_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, db, normal, out_valid, out_ready;
    logic [63:0] fa2, fb2;
    logic        sa, sb;
    logic [10:0] ea, eb;
    logic [5:0]  lza, lzb;
    logic [52:0] fa, fb, nan;
    logic [3:0]  fla, flb;

    unpacker_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fa2(fa2), .fb2(fb2), .db(db), .normal(normal),
        .out_valid(out_valid), .out_ready(out_ready),
        .sa(sa), .sb(sb), .ea(ea), .eb(eb), .lza(lza), .lzb(lzb),
        .fa(fa), .fb(fb), .fla(fla), .flb(flb), .nan(nan)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        sa, sb;
        logic [10:0] ea, eb;
        logic [5:0]  lza, lzb;
        logic [52:0] fa, fb, nan;
        logic [3:0]  fla, flb;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_seen = 1'b0;

    localparam logic [52:0] QN = 53'h18000000000000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic exp_t mk(input logic s_a, input logic [10:0] e_a, input logic [5:0] l_a,
                                input logic [52:0] f_a, input logic [3:0] fl_a,
                                input logic s_b, input logic [10:0] e_b, input logic [5:0] l_b,
                                input logic [52:0] f_b, input logic [3:0] fl_b,
                                input logic [52:0] nv, input bit lat);
        exp_t e;
        e.sa = s_a; e.ea = e_a; e.lza = l_a; e.fa = f_a; e.fla = fl_a;
        e.sb = s_b; e.eb = e_b; e.lzb = l_b; e.fb = f_b; e.flb = fl_b;
        e.nan = nv; e.acc = 0; e.lat = lat;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after acceptance with in_valid still high
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic d,
                         input logic n, input exp_t e);
        bit ok;
        exp_t ee;
        ee = e;
        fa2 = a; fb2 = b; db = d; normal = n; in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(posedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout: in_ready stayed 0, wanted 1");
        end else begin
            ee.acc = cyc;
            sb_q.push_back(ee);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, wanted 0", sb_q.size());
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                mon_seen = 1'b0;
            end else if (out_valid) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_output: out_valid=1, wanted 0 (no result pending)");
                end else begin
                    exp_t e;
                    e = sb_q[0];
                    if (!mon_seen && e.lat) check("latency", 64'(cyc - e.acc), 64'd2);
                    mon_seen = 1'b1;
                    check("sa",  64'(sa),  64'(e.sa));
                    check("sb",  64'(sb),  64'(e.sb));
                    check("ea",  64'(ea),  64'(e.ea));
                    check("eb",  64'(eb),  64'(e.eb));
                    check("lza", 64'(lza), 64'(e.lza));
                    check("lzb", 64'(lzb), 64'(e.lzb));
                    check("fa",  64'(fa),  64'(e.fa));
                    check("fb",  64'(fb),  64'(e.fb));
                    check("fla", 64'(fla), 64'(e.fla));
                    check("flb", 64'(flb), 64'(e.flb));
                    check("nan", 64'(nan), 64'(e.nan));
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        mon_seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check_reset_state();
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_in_ready",  64'(in_ready),  64'h1);
        check("rst_sa",        64'(sa),        64'h0);
        check("rst_ea",        64'(ea),        64'h0);
        check("rst_lza",       64'(lza),       64'h0);
        check("rst_fa",        64'(fa),        64'h0);
        check("rst_fb",        64'(fb),        64'h0);
        check("rst_fla",       64'(fla),       64'h0);
        check("rst_nan",       64'(nan),       64'h0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; fa2 = '0; fb2 = '0; db = 1'b0; normal = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();

        // Back-to-back, no stall: latency 2 checked for each
        issue({32'h428A0000, 32'h0}, {32'h428A0000, 32'h0}, 1'b0, 1'b1,
              mk(0, 11'h006, 0, 53'h11400000000000, 4'b0000,
                 0, 11'h006, 0, 53'h11400000000000, 4'b0000, QN, 1));
        issue(64'h1, 64'h0, 1'b1, 1'b1,
              mk(0, 11'h402, 6'd52, 53'h10000000000000, 4'b0000,
                 0, 11'h000, 0, 53'h0, 4'b0001, QN, 1));
        issue(64'h1, 64'h0, 1'b1, 1'b0,
              mk(0, 11'h402, 6'd52, 53'h1, 4'b0000,
                 0, 11'h000, 0, 53'h0, 4'b0001, QN, 1));
        issue(64'h7FF0000000000001, 64'h3FF0000000000000, 1'b1, 1'b1,
              mk(0, 11'h000, 0, 53'h10000000000001, 4'b1100,
                 0, 11'h000, 0, 53'h10000000000000, 4'b0000, 53'h18000000000001, 1));
        issue(64'h3FF0000000000000, 64'h7FF0000000000001, 1'b1, 1'b1,
              mk(0, 11'h000, 0, 53'h10000000000000, 4'b0000,
                 0, 11'h000, 0, 53'h10000000000001, 4'b1100, 53'h18000000000001, 1));
        issue({32'h80000000, 32'h0}, {32'h7F800000, 32'h0}, 1'b0, 1'b1,
              mk(1, 11'h000, 0, 53'h0, 4'b0001,
                 0, 11'h000, 0, 53'h0, 4'b0010, QN, 1));
        in_valid = 1'b0;
        drain();

        // Backpressure with mixed formats
        out_ready = 1'b0;
        issue(64'hC000000000000000, 64'h7FF0000000000000, 1'b1, 1'b1,
              mk(1, 11'h001, 0, 53'h10000000000000, 4'b0000,
                 0, 11'h000, 0, 53'h0, 4'b0010, QN, 0));
        issue({32'h3F800000, 32'h0}, {32'hFFC00001, 32'h0}, 1'b0, 1'b0,
              mk(0, 11'h000, 0, 53'h10000000000000, 4'b0000,
                 1, 11'h000, 0, 53'h18000020000000, 4'b0100, 53'h18000020000000, 0));
        fork
            begin
                issue({32'h00000001, 32'h0}, {32'h00800000, 32'h0}, 1'b0, 1'b1,
                      mk(0, 11'h782, 6'd23, 53'h10000000000000, 4'b0000,
                         0, 11'h782, 0, 53'h10000000000000, 4'b0000, QN, 0));
                in_valid = 1'b0;
            end
            begin
                repeat (3) begin
                    check("stall_in_ready",  64'(in_ready),  64'h0);
                    check("stall_out_valid", 64'(out_valid), 64'h1);
                    @(negedge clk);
                end
                out_ready = 1'b1;
                repeat (3) begin
                    check("release_out_valid", 64'(out_valid), 64'h1);
                    @(negedge clk);
                end
            end
        join
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        issue({32'h428A0000, 32'h0}, {32'h428A0000, 32'h0}, 1'b0, 1'b1,
              mk(0, 11'h006, 0, 53'h11400000000000, 4'b0000,
                 0, 11'h006, 0, 53'h11400000000000, 4'b0000, QN, 0));
        issue(64'h1, 64'h0, 1'b1, 1'b1,
              mk(0, 11'h402, 6'd52, 53'h10000000000000, 4'b0000,
                 0, 11'h000, 0, 53'h0, 4'b0001, QN, 0));
        in_valid = 1'b0;
        check("full_in_ready", 64'(in_ready), 64'h0);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        check_reset_state();
        issue({32'h00000001, 32'h0}, {32'h00800000, 32'h0}, 1'b0, 1'b0,
              mk(0, 11'h782, 6'd23, 53'h20000000, 4'b0000,
                 0, 11'h782, 0, 53'h10000000000000, 4'b0000, QN, 1));
        in_valid = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, wanted completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/unpacker_pipe.md
Name: unpacker_pipe

Overview:
- Pipelined, parametrised successor to the combinational two-operand unpacker in the FPU front end.
- Unpacks operands A and B in single or double precision into sign, unbiased exponent, leading-zero count, significand, class flags and a propagated quiet NaN.
- Two register stages with a valid/ready handshake, so the FPU issue logic can apply backpressure.
- Sits between the operand register file read and the add/mul/div datapaths.

Parameters:
- EXP_W, 11, wide-format exponent width (also width of ea/eb outputs).
- MAN_W, 52, wide-format stored fraction width; significand outputs are MAN_W+1 bits.
- SEXP_W, 8, narrow-format exponent width.
- SMAN_W, 23, narrow-format stored fraction width.
- LZ_W, 6, leading-zero count width; must satisfy 2^LZ_W > MAN_W.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  stage 1 can accept
- fa2, fb2  in  EXP_W+MAN_W+1 each  packed operands; narrow operands are left-justified (occupy the MSBs, low bits ignored)
- db  in  1  1 = wide format, 0 = narrow format
- normal  in  1  1 = shift significand left by lz, 0 = raw significand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- sa, sb  out  1  signs
- ea, eb  out  EXP_W  unbiased two's-complement exponents
- lza, lzb  out  LZ_W  leading-zero counts of the significands
- fa, fb  out  MAN_W+1  significands, hidden bit at the MSB
- fla, flb  out  4  flags {SNAN, NAN, INF, ZERO}, bits [3:0]
- nan  out  MAN_W+1  propagated quiet-NaN significand

Behaviour:
- Reset
  - Both stage valid bits clear on the next edge; out_valid=0.
  - All data outputs read 0.
  - in_ready=1 from the first cycle after reset.
  - Reset asserted mid-operation discards in-flight data; no partial outputs appear after reset.
- Handshake
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - Stage 2 loads when it is empty or out_ready=1.
  - in_ready = !s1_valid | stage-2 load.
  - Latency is exactly 2 cycles with no stall. Full throughput is 1 result per cycle.
  - While out_valid=1 and out_ready=0, every output is held stable.
  - Results leave in issue order; none is dropped or duplicated.
- Stage 1 (decode, registered)
  - Narrow field split: s = MSB; e = next SEXP_W bits; f = next SMAN_W bits.
  - Narrow significand = {h, f, (MAN_W−SMAN_W) zeros}.
  - Wide significand = {h, f}.
  - h = 1 if e≠0, else 0.
  - Exponent: e−bias for e≠0; 1−bias for e=0 (denormal). bias = 2^(width−1)−1 of the selected format. The result is sign-extended to EXP_W.
  - Class:
    - ZERO = e=0 & f=0
    - INF = e=all-ones & f=0
    - NAN = e=all-ones & f≠0
    - SNAN = NAN & fraction MSB=0
  - lz = leading zeros of the (MAN_W+1)-bit significand. Force lz=0 when ZERO, INF or NAN is set.
- Stage 2 (normalise, registered)
  - If normal=1, significand is shifted left by lz; otherwise it passes unchanged.
  - Exponent and lz pass unchanged; the consumer subtracts lz.
  - For ZERO and INF: f=0, e=0.
  - For NAN: e=0; f keeps its payload.
- NaN propagation
  - Source priority: A if NAN(A), else B if NAN(B).
  - nan = source significand with bit MAN_W forced to 1 (hidden bit) and bit MAN_W−1 forced to 1 (quiet bit).
  - If neither operand is a NaN, nan = canonical value {1, 1, zeros}.
- Mode
  - db and normal are sampled with the operands and travel with them.
  - Mixed-mode back-to-back issues are legal.

Test Plan:
- Narrow 69.0, fa2=fb2={32'h428A0000,32'h0}, db=0, normal=1, single issue.
  -> out_valid exactly 2 cycles after acceptance; sa=0; ea=11'h006; lza=0; fa=53'h11_4000_0000_0000; fla=0; nan=53'h18_0000_0000_0000.
- Wide denormal fa2=64'h1, normal=1.
  -> lza=52; ea=11'h402 (−1022); fa=53'h10_0000_0000_0000.
  - Repeat with normal=0.
  -> fa=53'h1; lza=52.
- Wide NaN cases.
  - fa2=64'h7FF0_0000_0000_0001 (SNaN), fb2=64'h3FF0_0000_0000_0000.
  -> fla=4'b1100; flb=0; ea=0; nan=53'h18_0000_0000_0001.
  - Swap the operands.
  -> flb=4'b1100; same nan.
- Narrow special values, fa2={32'h80000000,32'h0}, fb2={32'h7F800000,32'h0}.
  -> sa=1; fla=4'b0001; fa=0; lza=0; flb=4'b0010; eb=0; fb=0.
- Backpressure: out_ready=0 while 3 pairs are offered back-to-back.
  -> 2 pairs accepted; in_ready=0 afterwards; outputs stable.
  - Then out_ready=1.
  -> the three results emerge in order on consecutive cycles.
- Reset mid-operation: assert rst for 1 cycle with both stages full.
  -> out_valid=0 and outputs 0 after the edge; in_ready=1; the next issue has latency 2.
